// File: rtl/calc_req.sv
// Command front-end for a simple calculator: queues operand/op commands in a FIFO,
// issues them one at a time, watches for completion or timeout, and holds the result.
module calc_req #(
   parameter int unsigned DW      = 4,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cmd_valid,
   input  logic [1:0]    cmd_op,
   input  logic [DW-1:0] cmd_a,
   input  logic [DW-1:0] cmd_b,
   output logic          cmd_ready,
   output logic          go,
   output logic [1:0]    op,
   output logic [DW-1:0] in_a,
   output logic [DW-1:0] in_b,
   input  logic          done,
   input  logic [DW-1:0] result,
   output logic          res_valid,
   output logic [DW-1:0] res_data,
   output logic [1:0]    res_op,
   input  logic          res_ready,
   output logic          timeout,
   output logic          busy,
   output logic [7:0]    done_cnt,
   output logic [1:0]    state
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 2 * DW + 2;
   localparam int unsigned WW = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ISSUE = 2'b01,
      S_WAIT  = 2'b10,
      S_RESP  = 2'b11
   } state_t;

   state_t st, st_n;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, empty, push, pop;
   logic [EW-1:0] head;

   logic          go_n, res_valid_n, timeout_n, busy_n;
   logic [1:0]    op_n, res_op_n;
   logic [DW-1:0] in_a_n, in_b_n, res_data_n;
   logic [7:0]    done_cnt_n;
   logic [WW-1:0] wd, wd_n;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full && !rst;
   assign push      = cmd_valid && cmd_ready;
   assign head      = mem[rd_ptr];
   assign state     = st;

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
   end

   // FIFO pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_IDLE;
         go        <= 1'b0;
         op        <= '0;
         in_a      <= '0;
         in_b      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_op    <= '0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
         done_cnt  <= '0;
         wd        <= '0;
      end else begin
         st        <= st_n;
         go        <= go_n;
         op        <= op_n;
         in_a      <= in_a_n;
         in_b      <= in_b_n;
         res_valid <= res_valid_n;
         res_data  <= res_data_n;
         res_op    <= res_op_n;
         timeout   <= timeout_n;
         busy      <= busy_n;
         done_cnt  <= done_cnt_n;
         wd        <= wd_n;
      end
   end

   // Next-state and next-output logic; go is raised on entry to ISSUE so it is high there
   always_comb begin
      st_n       = st;
      pop        = 1'b0;
      go_n       = 1'b0;
      timeout_n  = 1'b0;
      op_n       = op;
      in_a_n     = in_a;
      in_b_n     = in_b;
      res_data_n = res_data;
      res_op_n   = res_op;
      done_cnt_n = done_cnt;
      wd_n       = wd;
      case (st)
         S_IDLE: begin
            if (!empty) begin
               pop    = 1'b1;
               op_n   = head[EW-1 -: 2];
               in_a_n = head[2*DW-1 -: DW];
               in_b_n = head[DW-1:0];
               go_n   = 1'b1;
               st_n   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wd_n = '0;
            st_n = S_WAIT;
         end
         S_WAIT: begin
            if (done) begin
               res_data_n = result;
               res_op_n   = op;
               done_cnt_n = done_cnt + 8'd1;
               st_n       = S_RESP;
            end else if (wd == WW'(TIMEOUT - 1)) begin
               timeout_n = 1'b1;
               st_n      = S_IDLE;
            end else begin
               wd_n = wd + WW'(1);
            end
         end
         S_RESP: begin
            if (res_ready) st_n = S_IDLE;
         end
         default: st_n = S_IDLE;
      endcase
      res_valid_n = (st_n == S_RESP);
      busy_n      = (st_n != S_IDLE);
   end

endmodule

// File: tb/tb_calc_req.sv
// Directed scoreboard bench for calc_req with a behavioural calculator model
// whose done latency is set per test.
module tb_calc_req;

   localparam int unsigned DW  = 4;
   localparam int unsigned TMO = 15;

   logic          clk;
   logic          rst;
   logic          cmd_valid;
   logic [1:0]    cmd_op;
   logic [DW-1:0] cmd_a, cmd_b;
   logic          cmd_ready;
   logic          go;
   logic [1:0]    op;
   logic [DW-1:0] in_a, in_b;
   logic          done = 1'b0;
   logic [DW-1:0] result = '0;
   logic          res_valid;
   logic [DW-1:0] res_data;
   logic [1:0]    res_op;
   logic          res_ready;
   logic          timeout;
   logic          busy;
   logic [7:0]    done_cnt;
   logic [1:0]    state;

   int vecs = 0;
   int errs = 0;
   int go_cnt = 0;
   int to_cnt = 0;
   int wait_len = 0;
   int lat = 1;
   int mcnt = 0;
   logic [DW+1:0] sb [$];

   calc_req #(.DW(DW), .DEPTH(4), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
      .cmd_ready(cmd_ready),
      .go(go), .op(op), .in_a(in_a), .in_b(in_b),
      .done(done), .result(result),
      .res_valid(res_valid), .res_data(res_data), .res_op(res_op),
      .res_ready(res_ready),
      .timeout(timeout), .busy(busy), .done_cnt(done_cnt), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] calc(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (o)
         2'd0:    calc = a + b;
         2'd1:    calc = a - b;
         2'd2:    calc = a & b;
         default: calc = a ^ b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Calculator model: done pulses 'lat' cycles after go is seen (lat=0 never answers)
   always @(negedge clk) begin
      done = 1'b0;
      if (rst) begin
         mcnt = 0;
      end else begin
         if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
               done   = 1'b1;
               result = calc(op, in_a, in_b);
            end
         end
         if (go && lat > 0) mcnt = lat;
      end
   end

   // Monitor: event counters, WAIT length at timeout, scoreboard pop on result handshake
   always @(negedge clk) begin
      logic [DW+1:0] exp_e;
      if (!rst) begin
         if (go) begin
            go_cnt++;
            wait_len = 0;
         end
         if (state == 2'b10) wait_len++;
         if (timeout) begin
            to_cnt++;
            chk("timeout_wait_len", wait_len, TMO);
         end
         if (res_valid && res_ready) begin
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               exp_e = sb.pop_front();
               chk("res_data", res_data, exp_e[DW-1:0]);
               chk("res_op", res_op, exp_e[DW+1:DW]);
            end
         end
      end
   end

   task automatic push(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b, input bit exp_res);
      int n = 0;
      cmd_valid = 1'b1;
      cmd_op    = o;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk("push_accept", 32'(cmd_ready), 1);
      if (exp_res) sb.push_back({o, calc(o, a, b)});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      int quiet = 0;
      while (quiet < 3 && n < 3000) begin
         if (sb.size() == 0 && state == 2'b00) quiet++;
         else quiet = 0;
         @(posedge clk); #1;
         n++;
      end
      chk("drain_in_time", 32'(quiet >= 3), 1);
   endtask

   task automatic wait_to(input int target);
      int n = 0;
      while (to_cnt < target && n < 400) begin
         @(posedge clk); #1;
         n++;
      end
      chk("timeouts_seen", to_cnt, target);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state, 0);
      chk({tag, "_go"}, go, 0);
      chk({tag, "_op"}, op, 0);
      chk({tag, "_in_a"}, in_a, 0);
      chk({tag, "_in_b"}, in_b, 0);
      chk({tag, "_res_valid"}, res_valid, 0);
      chk({tag, "_res_data"}, res_data, 0);
      chk({tag, "_res_op"}, res_op, 0);
      chk({tag, "_timeout"}, timeout, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done_cnt"}, done_cnt, 0);
      chk({tag, "_cmd_ready"}, cmd_ready, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int g, t, c, n;
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst = 1'b0;
      #1;
      chk("ready_after_reset", cmd_ready, 1);

      // Minimum latency: ADD 3+5
      lat = 1;
      cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 4'd3; cmd_b = 4'd5;
      sb.push_back({2'd0, 4'd8});
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("lat_c1_state", state, 0);
      @(posedge clk); #1;
      chk("lat_c2_go", go, 1);
      chk("lat_c2_state", state, 1);
      chk("lat_c2_in_a", in_a, 3);
      chk("lat_c2_in_b", in_b, 5);
      chk("lat_c2_busy", busy, 1);
      @(posedge clk); #1;
      chk("lat_c3_go", go, 0);
      chk("lat_c3_state", state, 2);
      chk("lat_c3_in_a", in_a, 3);
      @(posedge clk); #1;
      chk("lat_c4_res_valid", res_valid, 1);
      chk("lat_c4_res_data", res_data, 8);
      chk("lat_c4_res_op", res_op, 0);
      chk("lat_c4_done_cnt", done_cnt, 1);
      @(posedge clk); #1;
      chk("lat_c5_state", state, 0);
      chk("lat_c5_res_valid", res_valid, 0);
      chk("lat_go_once", go_cnt, 1);

      // All operations, with wraparound, done two cycles after go
      lat = 2;
      push(2'd1, 4'd2, 4'd5, 1'b1);
      push(2'd2, 4'hc, 4'ha, 1'b1);
      push(2'd3, 4'hc, 4'ha, 1'b1);
      push(2'd0, 4'hf, 4'h1, 1'b1);
      drain();
      chk("ops_done_cnt", done_cnt, 5);

      // Result backpressure
      lat = 1;
      res_ready = 1'b0;
      push(2'd0, 4'd1, 4'd2, 1'b1);
      push(2'd1, 4'd7, 4'd3, 1'b1);
      n = 0;
      while (!res_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      g = go_cnt;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_res_valid", res_valid, 1);
         chk("bp_res_data", res_data, 3);
         chk("bp_state", state, 3);
      end
      chk("bp_no_go", go_cnt, g);
      res_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_state", state, 0);
      @(posedge clk); #1;
      chk("bp_next_go", go, 1);
      drain();

      // Timeouts with a full FIFO
      lat = 0;
      t = to_cnt; g = go_cnt; c = int'(done_cnt);
      for (int i = 0; i < 5; i++) push(2'(i), 4'(i), 4'(i), 1'b0);
      chk("full_cmd_ready", cmd_ready, 0);
      push(2'd0, 4'd9, 4'd9, 1'b0);
      wait_to(t + 6);
      chk("to_go_count", go_cnt - g, 6);
      chk("to_done_cnt", done_cnt, 32'(c));
      drain();

      // done on the last watchdog cycle wins; one cycle later is a timeout
      lat = 15;
      t = to_cnt;
      push(2'd3, 4'd5, 4'd6, 1'b1);
      drain();
      chk("edge_no_timeout", to_cnt, t);
      chk("edge_done_cnt", done_cnt, 32'(8'(c + 1)));
      lat = 16;
      push(2'd0, 4'd1, 4'd1, 1'b0);
      wait_to(t + 1);
      drain();
      chk("late_done_ignored", done_cnt, 32'(8'(c + 1)));

      // Reset during WAIT with queued commands
      lat = 0;
      push(2'd0, 4'd1, 4'd1, 1'b0);
      push(2'd0, 4'd2, 4'd2, 1'b0);
      push(2'd0, 4'd3, 4'd3, 1'b0);
      n = 0;
      while (state != 2'b10 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("pre_rst_wait", state, 2);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset_vals("midrst");
      rst = 1'b0;
      g = go_cnt; t = to_cnt;
      repeat (30) @(posedge clk);
      #1;
      chk("midrst_no_go", go_cnt, g);
      chk("midrst_no_timeout", to_cnt, t);
      chk("midrst_cmd_ready", cmd_ready, 1);
      lat = 1;
      push(2'd1, 4'd9, 4'd4, 1'b1);
      drain();
      chk("postrst_go", go_cnt, g + 1);
      chk("postrst_done_cnt", done_cnt, 1);

      // done_cnt wrap after 256 completions since reset
      for (int i = 0; i < 254; i++)
         push(2'($urandom_range(3)), DW'($urandom), DW'($urandom), 1'b1);
      drain();
      chk("wrap_255", done_cnt, 255);
      push(2'd2, 4'hf, 4'h6, 1'b1);
      drain();
      chk("wrap_0", done_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
